// File: rtl/vote_logger.sv
// Six-candidate ballot logger: one vote per clean single-button press, then a
// fixed lockout and a wait-for-release before the next ballot is taken.
module vote_logger #(
    parameter int LOCKOUT_CYCLES = 100000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mode,
    input  logic       candidate1_button_pressed,
    input  logic       candidate2_button_pressed,
    input  logic       candidate3_button_pressed,
    input  logic       candidate4_button_pressed,
    input  logic       candidate5_button_pressed,
    input  logic       candidate6_button_pressed,
    output logic [7:0] candidate1_vote,
    output logic [7:0] candidate2_vote,
    output logic [7:0] candidate3_vote,
    output logic [7:0] candidate4_vote,
    output logic [7:0] candidate5_vote,
    output logic [7:0] candidate6_vote,
    output logic       valid_vote_casted,
    output logic       invalid_attempt,
    output logic       busy
);

    // state        | meaning
    // IDLE         | ready; buttons sampled every edge when mode=0
    // LOCKOUT      | counting down after an accepted vote, buttons ignored
    // WAIT_RELEASE | holding until every button is low
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        LOCKOUT      = 2'd1,
        WAIT_RELEASE = 2'd2
    } state_t;

    localparam logic [30:0] LOCK_LOAD = 31'(LOCKOUT_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [30:0] lock_cnt;
    logic [5:0]  btn;
    logic [7:0]  tally [6];
    logic        single_press;
    logic        multi_press;
    logic        accept;
    logic        reject;

    assign btn = {candidate6_button_pressed, candidate5_button_pressed,
                  candidate4_button_pressed, candidate3_button_pressed,
                  candidate2_button_pressed, candidate1_button_pressed};

    assign single_press = (btn != 6'd0) && ((btn & (btn - 6'd1)) == 6'd0);
    assign multi_press  = (btn != 6'd0) && !single_press;

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            lock_cnt          <= '0;
            valid_vote_casted <= 1'b0;
            invalid_attempt   <= 1'b0;
            for (int i = 0; i < 6; i++) tally[i] <= 8'h00;
        end else begin
            state             <= state_next;
            valid_vote_casted <= accept;
            invalid_attempt   <= reject;
            if (accept)
                lock_cnt <= LOCK_LOAD;
            else if (state == LOCKOUT && lock_cnt != 31'd0)
                lock_cnt <= lock_cnt - 31'd1;
            // Saturate at 255; the vote still counts as accepted.
            for (int i = 0; i < 6; i++)
                if (accept && btn[i] && tally[i] != 8'hFF)
                    tally[i] <= tally[i] + 8'd1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!mode && single_press)
                    state_next = LOCKOUT;
                else if (!mode && multi_press)
                    state_next = WAIT_RELEASE;
            end
            LOCKOUT: begin
                if (lock_cnt == 31'd0)
                    state_next = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (btn == 6'd0)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        accept = 1'b0;
        reject = 1'b0;
        if (state == IDLE && !mode) begin
            accept = single_press;
            reject = multi_press;
        end
    end

    assign busy            = (state != IDLE);
    assign candidate1_vote = tally[0];
    assign candidate2_vote = tally[1];
    assign candidate3_vote = tally[2];
    assign candidate4_vote = tally[3];
    assign candidate5_vote = tally[4];
    assign candidate6_vote = tally[5];

endmodule

// File: doc/vote_logger.md
VOTE_LOGGER -- requirements
Module: vote_logger

Interface
REQ-001 The module SHALL have parameter LOCKOUT_CYCLES, default 100000000, meaning the cycles in LOCKOUT after each accepted vote (legal range 1 to 2^31-1).
REQ-002 Port clock, input, 1, is the single clock; all logic is on the rising edge.
REQ-003 Port reset, input, 1, is the reset: synchronous, active-high.
REQ-004 Port mode, input, 1, selects the mode: 0 = voting, 1 = result display (no votes recorded).
REQ-005 Ports candidate1_button_pressed .. candidate6_button_pressed, input, 1 each, are debounced ballot buttons, level-sensitive.
REQ-006 Ports candidate1_vote .. candidate6_vote, output, 8 each, are per-candidate tallies.
REQ-007 Port valid_vote_casted, output, 1, is a single-cycle pulse per accepted vote.
REQ-008 Port invalid_attempt, output, 1, is a single-cycle pulse per rejected multi-button press.
REQ-009 Port busy, output, 1, is high whenever the state is not IDLE.

Function
REQ-010 The state machine SHALL have three states: IDLE, LOCKOUT, WAIT_RELEASE.
REQ-011 IDLE with mode=0 and exactly one button high at a clock edge SHALL, at that edge:
- increment that candidate's tally by 1;
- set valid_vote_casted=1 for the following cycle only;
- enter LOCKOUT with the lockout counter loaded to LOCKOUT_CYCLES-1.
REQ-012 Vote latency SHALL be one cycle: the tally and the pulse are visible in the cycle after the sampling edge.
REQ-013 IDLE with mode=0 and two or more buttons high SHALL leave all tallies unchanged, pulse invalid_attempt for one cycle, and enter WAIT_RELEASE.
REQ-014 IDLE with mode=1 SHALL ignore all buttons: no tally change, no pulse, state stays IDLE.
REQ-015 LOCKOUT SHALL decrement the counter each cycle and ignore buttons; at counter=0 it SHALL enter WAIT_RELEASE on the next edge. LOCKOUT therefore lasts exactly LOCKOUT_CYCLES cycles.
REQ-016 WAIT_RELEASE SHALL remain until all six buttons are low at an edge, then enter IDLE. A held button SHALL never yield a second vote.
REQ-017 A mode change during LOCKOUT or WAIT_RELEASE SHALL NOT abort or shorten the sequence.
REQ-018 Tallies SHALL saturate at 8'hFF: a vote for a candidate already at 255 leaves the tally at 255, still pulses valid_vote_casted, and still enters LOCKOUT.
REQ-019 valid_vote_casted and invalid_attempt SHALL never be high in the same cycle.
REQ-020 Outputs SHALL be registered only; no combinational path from any input to any output.

Reset
REQ-021 reset=1 at an edge SHALL, on that edge, set:
- all six tallies to 8'h00;
- valid_vote_casted=0, invalid_attempt=0, busy=0;
- state to IDLE and the lockout counter to 0.
REQ-022 Reset SHALL take precedence over every other input, including a button press at the same edge and a reset asserted mid-LOCKOUT.
REQ-023 After reset deasserts, a button already held high SHALL be accepted as a vote, since IDLE is level-sensitive.

Verification (LOCKOUT_CYCLES=4)
REQ-024 Single vote: reset, mode=0, button2 high for 1 cycle -> candidate2_vote=1 one cycle later, valid_vote_casted high exactly 1 cycle, busy high for 4 LOCKOUT cycles plus WAIT_RELEASE, then busy=0.
REQ-025 Held button: button1 held 20 cycles -> candidate1_vote=1 only; a release and re-press -> candidate1_vote=2.
REQ-026 Simultaneous press: button3 and button5 high in the same cycle -> invalid_attempt pulses once, all tallies 0, no vote until both are released.
REQ-027 Saturation: 256 separate votes for candidate6 -> candidate6_vote=255, 256 valid_vote_casted pulses.
REQ-028 Result mode: mode=1, press each button -> all tallies unchanged, no pulses, busy=0.
REQ-029 Reset mid-lockout: reset at the 2nd LOCKOUT cycle -> next cycle all tallies 0, busy=0; a fresh press is accepted immediately.
